// File: rtl/fp32_pkg.sv
// Shared definitions for the IEEE-754 single-precision arithmetic blocks.
// Holds field widths, the packed word layout, the canonical quiet NaN,
// the subtractor FSM state encoding and a sign-flip helper.
package fp32_pkg;

  localparam int unsigned EXP_W  = 8;
  localparam int unsigned FRAC_W = 23;
  // {hidden, frac, 23 guard bits}
  localparam int unsigned MANT_W = 47;
  // Mantissa plus carry and sign
  localparam int unsigned SUM_W  = MANT_W + 2;
  // Unsigned magnitude of the sum: mantissa plus carry
  localparam int unsigned MAG_W  = MANT_W + 1;

  localparam logic [EXP_W-1:0] EXP_MAX      = 8'hFF;
  localparam logic [31:0]      QNAN_DEFAULT = 32'hFFC00000;

  typedef struct packed {
    logic              sign;
    logic [EXP_W-1:0]  expo;
    logic [FRAC_W-1:0] frac;
  } fp32_t;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ALIGN = 3'd1,
    ADD   = 3'd2,
    NORM  = 3'd3,
    DONE  = 3'd4
  } state_e;

  // Flip the sign bit only; NaN payloads are left untouched
  function automatic fp32_t negate(input fp32_t v);
    fp32_t r;
    r      = v;
    r.sign = ~v.sign;
    return r;
  endfunction

endpackage

// File: rtl/fp32_special.sv
// Combinational special-case resolver for a - b, given a and nb = -b.
// Ports:
//   a          minuend
//   nb         subtrahend with its sign flipped
//   is_special either operand has an all-ones exponent
//   result     resolved result, valid when is_special is set
module fp32_special
  import fp32_pkg::*;
#(
  parameter logic [31:0] QNAN_CANON = QNAN_DEFAULT
) (
  input  fp32_t a,
  input  fp32_t nb,
  output logic  is_special,
  output fp32_t result
);

  logic  a_max;
  logic  b_max;
  logic  a_nan;
  logic  b_nan;
  fp32_t b_orig;

  // Priority: a NaN, then a inf, then b inf/NaN
  always_comb begin
    b_orig     = negate(nb);
    a_max      = (a.expo == EXP_MAX);
    b_max      = (nb.expo == EXP_MAX);
    a_nan      = a_max && (a.frac != '0);
    b_nan      = b_max && (nb.frac != '0);
    is_special = a_max || b_max;
    result     = '0;
    if (a_nan) begin
      result = a;
    end else if (a_max) begin
      if (b_nan) begin
        result = b_orig;
      end else if (b_max && (a.sign != nb.sign)) begin
        // a and b are infinities of the same sign: inf - inf
        result = fp32_t'(QNAN_CANON);
      end else begin
        result = a;
      end
    end else if (b_max) begin
      result = b_nan ? b_orig : nb;
    end
  end

endmodule

// File: rtl/fp_subtractor_seq.sv
// Multi-cycle IEEE-754 single-precision subtractor: diff = a - b.
// Truncating, denormal-aware; normalisation shifts one bit per cycle.
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   in_valid / in_ready operand handshake (ready only while idle)
//   a, b                minuend and subtrahend
//   out_valid/out_ready result handshake
//   diff                result, held stable while out_valid is high
module fp_subtractor_seq
  import fp32_pkg::*;
#(
  parameter logic [31:0] QNAN_CANON = QNAN_DEFAULT,
  parameter logic        ZERO_SIGN  = 1'b0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] diff
);

  state_e state;
  state_e state_next;

  fp32_t             op_a, op_a_d;
  fp32_t             op_nb, op_nb_d;
  logic [EXP_W-1:0]  ex_q, ex_d;
  logic [MANT_W-1:0] mx_q, mx_d;
  logic [MANT_W-1:0] my_q, my_d;
  logic [MANT_W-1:0] m_q, m_d;
  logic              sx_q, sx_d;
  logic              sy_q, sy_d;
  logic              s_q, s_d;
  logic [31:0]       diff_d;
  logic              in_ready_d;
  logic              out_valid_d;

  logic  accept;
  fp32_t nb_in;
  logic  sp_hit;
  fp32_t sp_result;

  assign accept = in_valid && in_ready;
  assign nb_in  = negate(fp32_t'(b));

  fp32_special #(
    .QNAN_CANON(QNAN_CANON)
  ) u_special (
    .a         (fp32_t'(a)),
    .nb        (nb_in),
    .is_special(sp_hit),
    .result    (sp_result)
  );

  // Alignment: order by effective exponent and shift the smaller operand
  logic [EXP_W-1:0]  ea, eb, x_e, y_e, shamt;
  logic [MANT_W-1:0] ma, mb, x_m, y_m, y_sh;
  logic              x_s, y_s, swap;

  always_comb begin
    // A zero exponent field behaves as exponent 1 without the hidden bit
    ea    = (op_a.expo == '0) ? EXP_W'(1) : op_a.expo;
    eb    = (op_nb.expo == '0) ? EXP_W'(1) : op_nb.expo;
    ma    = {op_a.expo != '0, op_a.frac, FRAC_W'(0)};
    mb    = {op_nb.expo != '0, op_nb.frac, FRAC_W'(0)};
    swap  = (eb > ea);
    x_e   = swap ? eb : ea;
    y_e   = swap ? ea : eb;
    x_m   = swap ? mb : ma;
    y_m   = swap ? ma : mb;
    x_s   = swap ? op_nb.sign : op_a.sign;
    y_s   = swap ? op_a.sign : op_nb.sign;
    shamt = x_e - y_e;
    y_sh  = (shamt >= EXP_W'(MANT_W)) ? '0 : (y_m >> shamt);
  end

  // Signed add of the aligned mantissas, then sign/magnitude split
  logic [SUM_W-1:0] vx, vy, sum;
  logic             sum_s;
  logic [MAG_W-1:0] mag;
  logic             add_ovf, add_zero, add_fin;

  always_comb begin
    vx       = sx_q ? (SUM_W'(0) - SUM_W'(mx_q)) : SUM_W'(mx_q);
    vy       = sy_q ? (SUM_W'(0) - SUM_W'(my_q)) : SUM_W'(my_q);
    sum      = vx + vy;
    sum_s    = sum[SUM_W-1];
    mag      = MAG_W'(sum_s ? (SUM_W'(0) - sum) : sum);
    add_ovf  = mag[MAG_W-1];
    add_zero = (mag == '0);
    // Already normalised, or no exponent room left to shift into
    add_fin  = mag[MANT_W-1] || (ex_q == EXP_W'(1));
  end

  // One normalisation step; exit is judged on the shifted value
  logic [MANT_W-1:0] norm_m;
  logic [EXP_W-1:0]  norm_e;
  logic              norm_exit;

  always_comb begin
    norm_m    = m_q << 1;
    norm_e    = ex_q - EXP_W'(1);
    norm_exit = norm_m[MANT_W-1] || (norm_e == EXP_W'(1));
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (accept) state_next = sp_hit ? DONE : ALIGN;
      ALIGN:   state_next = ADD;
      ADD:     if (add_ovf || add_zero || add_fin) state_next = DONE;
               else state_next = NORM;
      NORM:    if (norm_exit) state_next = DONE;
      DONE:    if (out_valid && out_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Output and datapath next values
  always_comb begin
    op_a_d      = op_a;
    op_nb_d     = op_nb;
    ex_d        = ex_q;
    mx_d        = mx_q;
    my_d        = my_q;
    m_d         = m_q;
    sx_d        = sx_q;
    sy_d        = sy_q;
    s_d         = s_q;
    diff_d      = diff;
    in_ready_d  = (state_next == IDLE);
    // out_valid rises one cycle after entering DONE and drops on handshake
    out_valid_d = (state == DONE) && !(out_valid && out_ready);
    case (state)
      IDLE: begin
        if (accept) begin
          op_a_d  = fp32_t'(a);
          op_nb_d = nb_in;
          if (sp_hit) diff_d = sp_result;
        end
      end
      ALIGN: begin
        ex_d = x_e;
        mx_d = x_m;
        my_d = y_sh;
        sx_d = x_s;
        sy_d = y_s;
      end
      ADD: begin
        s_d = sum_s;
        m_d = mag[MANT_W-1:0];
        if (add_ovf) begin
          if (ex_q >= 8'hFE) diff_d = {sum_s, EXP_MAX, FRAC_W'(0)};
          else diff_d = {sum_s, ex_q + EXP_W'(1), mag[MANT_W-1 -: FRAC_W]};
        end else if (add_zero) begin
          diff_d = {ZERO_SIGN, 31'h0};
        end else if (add_fin) begin
          diff_d = {sum_s, mag[MANT_W-1] ? ex_q : EXP_W'(0), mag[MANT_W-2 -: FRAC_W]};
        end
      end
      NORM: begin
        m_d  = norm_m;
        ex_d = norm_e;
        if (norm_exit) begin
          diff_d = {s_q, norm_m[MANT_W-1] ? norm_e : EXP_W'(0),
                    norm_m[MANT_W-2 -: FRAC_W]};
        end
      end
      default: ;
    endcase
  end

  // Registered outputs and datapath
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_a      <= '0;
      op_nb     <= '0;
      ex_q      <= '0;
      mx_q      <= '0;
      my_q      <= '0;
      m_q       <= '0;
      sx_q      <= 1'b0;
      sy_q      <= 1'b0;
      s_q       <= 1'b0;
      diff      <= '0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
    end else begin
      op_a      <= op_a_d;
      op_nb     <= op_nb_d;
      ex_q      <= ex_d;
      mx_q      <= mx_d;
      my_q      <= my_d;
      m_q       <= m_d;
      sx_q      <= sx_d;
      sy_q      <= sy_d;
      s_q       <= s_d;
      diff      <= diff_d;
      in_ready  <= in_ready_d;
      out_valid <= out_valid_d;
    end
  end

endmodule

// File: tb/tb_fp_subtractor_seq.sv
// Directed self-checking bench for fp_subtractor_seq.
module tb_fp_subtractor_seq;

  localparam int LAT_MAX = 100;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] a;
  logic [31:0] b;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] diff;

  int errors = 0;
  int checks = 0;

  fp_subtractor_seq dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .a        (a),
    .b        (b),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .diff     (diff)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  // Present one operation, return result and latency in cycles
  task automatic run_op(input logic [31:0] av, input logic [31:0] bv,
                        output logic [31:0] res, output int lat);
    @(negedge clk);
    a        = av;
    b        = bv;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    lat = 0;
    while (out_valid !== 1'b1 && lat < LAT_MAX) begin
      @(posedge clk);
      #1;
      lat++;
    end
    res = diff;
  endtask

  task automatic drain();
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    a         = '0;
    b         = '0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (in_ready !== 1'b1) begin errors++; $display("FAIL reset in_ready: got %b want 1", in_ready); end
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL reset out_valid: got %b want 0", out_valid); end
    checks++;
    if (diff !== 32'h0) begin errors++; $display("FAIL reset diff: got %h want 00000000", diff); end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_normal();
    logic [31:0] va[5], vb[5], ve[5];
    int          vl[5];
    logic [31:0] res;
    int          lat;
    va = '{32'h40400000, 32'h40A00000, 32'h3F800000, 32'h3F800000, 32'h4B800000};
    vb = '{32'h3F800000, 32'h40400000, 32'h40000000, 32'h30800000, 32'h33800000};
    ve = '{32'h40000000, 32'h40000000, 32'hBF800000, 32'h3F7FFFFF, 32'h4B800000};
    vl = '{3, 4, 4, 4, 3};
    for (int i = 0; i < 5; i++) begin
      run_op(va[i], vb[i], res, lat);
      checks++;
      if (res !== ve[i]) begin errors++; $display("FAIL normal[%0d] diff: got %h want %h", i, res, ve[i]); end
      checks++;
      if (lat !== vl[i]) begin errors++; $display("FAIL normal[%0d] latency: got %0d want %0d", i, lat, vl[i]); end
      drain();
    end
  endtask

  task automatic test_overflow_zero();
    logic [31:0] va[5], vb[5], ve[5];
    logic [31:0] res;
    int          lat;
    va = '{32'h3F800000, 32'h7F7FFFFF, 32'h3F800000, 32'hBF800000, 32'hBF800000};
    vb = '{32'hBF800000, 32'hFF7FFFFF, 32'h3F800000, 32'hBF800000, 32'h3F800000};
    ve = '{32'h40000000, 32'h7F800000, 32'h00000000, 32'h00000000, 32'hC0000000};
    for (int i = 0; i < 5; i++) begin
      run_op(va[i], vb[i], res, lat);
      checks++;
      if (res !== ve[i]) begin errors++; $display("FAIL ovf_zero[%0d] diff: got %h want %h", i, res, ve[i]); end
      checks++;
      if (lat !== 3) begin errors++; $display("FAIL ovf_zero[%0d] latency: got %0d want 3", i, lat); end
      drain();
    end
  endtask

  task automatic test_denormal();
    logic [31:0] va[3], vb[3], ve[3];
    logic [31:0] res;
    int          lat;
    va = '{32'h00000003, 32'h00800000, 32'h00000001};
    vb = '{32'h00000001, 32'h00000001, 32'h00000003};
    ve = '{32'h00000002, 32'h007FFFFF, 32'h80000002};
    for (int i = 0; i < 3; i++) begin
      run_op(va[i], vb[i], res, lat);
      checks++;
      if (res !== ve[i]) begin errors++; $display("FAIL denorm[%0d] diff: got %h want %h", i, res, ve[i]); end
      checks++;
      if (lat !== 3) begin errors++; $display("FAIL denorm[%0d] latency: got %0d want 3", i, lat); end
      drain();
    end
  endtask

  task automatic test_special();
    logic [31:0] va[7], vb[7], ve[7];
    logic [31:0] res;
    int          lat;
    va = '{32'h7F800000, 32'h7F800000, 32'h3F800000, 32'h7FC12345,
           32'h7F800000, 32'h3F800000, 32'hFF800000};
    vb = '{32'h7F800000, 32'h7FC00001, 32'h7F800000, 32'h3F800000,
           32'hFF800000, 32'hFFC00005, 32'h3F800000};
    ve = '{32'hFFC00000, 32'h7FC00001, 32'hFF800000, 32'h7FC12345,
           32'h7F800000, 32'hFFC00005, 32'hFF800000};
    for (int i = 0; i < 7; i++) begin
      run_op(va[i], vb[i], res, lat);
      checks++;
      if (res !== ve[i]) begin errors++; $display("FAIL special[%0d] diff: got %h want %h", i, res, ve[i]); end
      checks++;
      if (lat !== 1) begin errors++; $display("FAIL special[%0d] latency: got %0d want 1", i, lat); end
      drain();
    end
  endtask

  task automatic test_long_norm();
    logic [31:0] res;
    int          lat;
    run_op(32'h3F800000, 32'h3F7FFFFF, res, lat);
    checks++;
    if (res !== 32'h33800000) begin errors++; $display("FAIL long_norm diff: got %h want 33800000", res); end
    checks++;
    if (lat !== 27) begin errors++; $display("FAIL long_norm latency: got %0d want 27", lat); end
    drain();
  endtask

  task automatic test_back_to_back();
    logic [31:0] res;
    int          lat;
    run_op(32'h40400000, 32'h3F800000, res, lat);
    checks++;
    if (res !== 32'h40000000) begin errors++; $display("FAIL hold diff: got %h want 40000000", res); end
    // Offer a second operation while the result is stalled
    a        = 32'h40A00000;
    b        = 32'hC0A00000;
    in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      checks++;
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || diff !== 32'h40000000) begin
        errors++;
        $display("FAIL hold[%0d]: out_valid=%b in_ready=%b diff=%h want 1 0 40000000",
                 i, out_valid, in_ready, diff);
      end
    end
    drain();
    in_valid = 1'b0;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL release: out_valid=%b in_ready=%b want 0 1", out_valid, in_ready);
    end
    run_op(32'h3F800000, 32'h3F800000, res, lat);
    checks++;
    if (res !== 32'h00000000 || lat !== 3) begin
      errors++;
      $display("FAIL after_hold: diff=%h lat=%0d want 00000000 3", res, lat);
    end
    drain();
  endtask

  task automatic test_reset_mid_norm();
    logic [31:0] res;
    int          lat;
    // Leave a non-zero result behind so the reset clear is visible
    run_op(32'h40400000, 32'h3F800000, res, lat);
    drain();
    @(negedge clk);
    a        = 32'h3F800000;
    b        = 32'h3F7FFFFF;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (6) @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || diff !== 32'h0) begin
      errors++;
      $display("FAIL mid_reset: out_valid=%b in_ready=%b diff=%h want 0 1 00000000",
               out_valid, in_ready, diff);
    end
    @(negedge clk);
    rst_n = 1'b1;
    run_op(32'h40400000, 32'h3F800000, res, lat);
    checks++;
    if (res !== 32'h40000000) begin errors++; $display("FAIL post_reset diff: got %h want 40000000", res); end
    checks++;
    if (lat !== 3) begin errors++; $display("FAIL post_reset latency: got %0d want 3", lat); end
    drain();
  endtask

  initial begin
    test_reset();
    test_normal();
    test_overflow_zero();
    test_denormal();
    test_special();
    test_long_norm();
    test_back_to_back();
    test_reset_mid_norm();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
